clkgen_div_n: RTL and testbench



---
 rtl/clkgen_pkg.sv | 19 +
 rtl/clkgen_chan.sv | 55 +++++
 rtl/clkgen_div_n.sv | 90 +++++++++
 tb/tb_clkgen_div_n.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/clkgen_pkg.sv
// Shared constants and helpers for the multi-channel fabric clock generator.
package clkgen_pkg;

  localparam logic [1:0] ST_SETTLE = 2'd0;
  localparam logic [1:0] ST_LOCKED = 2'd1;
  localparam logic [1:0] ST_UPDATE = 2'd2;

  localparam int unsigned DIV_RESET  = 2;
  localparam int unsigned HIGH_RESET = 1;

  function automatic logic [31:0] clamp(input logic [31:0] v,
                                        input logic [31:0] lo,
                                        input logic [31:0] hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/clkgen_chan.sv
// One divided-clock channel: config registers, period counter, resync load and
// registered clock / clock-enable outputs.
module clkgen_chan
  import clkgen_pkg::*;
#(
  parameter int DIV_W = 16
) (
  input  logic             refclk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [DIV_W-1:0] wr_div,
  input  logic [DIV_W-1:0] wr_high,
  input  logic [DIV_W-1:0] wr_phase,
  input  logic             resync,
  input  logic             force_low,
  output logic             outclk,
  output logic             outclk_en
);

  localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

  logic [DIV_W-1:0] div_q, high_q, phase_q, cnt_q;
  logic [DIV_W-1:0] div_c, high_c, phase_c, load, last;

  // high and phase are clamped against the already-clamped period
  assign div_c   = DIV_W'(clamp(32'(wr_div), 32'(DIV_RESET), 32'hFFFF_FFFF));
  assign high_c  = DIV_W'(clamp(32'(wr_high), 32'(HIGH_RESET), 32'(div_c - ONE)));
  assign phase_c = DIV_W'(clamp(32'(wr_phase), 32'd0, 32'(div_c - ONE)));

  assign last = div_q - ONE;
  assign load = (phase_q == '0) ? '0 : div_q - phase_q;

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      div_q     <= DIV_W'(DIV_RESET);
      high_q    <= DIV_W'(HIGH_RESET);
      phase_q   <= '0;
      cnt_q     <= '0;
      outclk    <= 1'b0;
      outclk_en <= 1'b0;
    end else begin
      if (wr_en) begin
        div_q   <= div_c;
        high_q  <= high_c;
        phase_q <= phase_c;
      end
      if (resync)             cnt_q <= load;
      else if (cnt_q >= last) cnt_q <= '0;
      else                    cnt_q <= cnt_q + ONE;
      outclk    <= !force_low && (cnt_q < high_q);
      outclk_en <= !force_low && (cnt_q == '0);
    end
  end

endmodule

// File: rtl/clkgen_div_n.sv
// Multi-output fabric clock generator: config decode, lock sequencing FSM and
// NUM_CLOCKS phase-aligned divider channels.
//   state  | meaning
//   SETTLE | channels running, settle counter counting down to lock
//   LOCKED | locked=1, all channels aligned with current settings
//   UPDATE | one cycle: resync all counters, outputs held low
module clkgen_div_n
  import clkgen_pkg::*;
#(
  parameter int NUM_CLOCKS  = 4,
  parameter int DIV_W       = 16,
  parameter int LOCK_CYCLES = 16,
  localparam int CHAN_W     = (NUM_CLOCKS > 1) ? $clog2(NUM_CLOCKS) : 1
) (
  input  logic                  refclk,
  input  logic                  rst_n,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [CHAN_W-1:0]     cfg_chan,
  input  logic [DIV_W-1:0]      cfg_div,
  input  logic [DIV_W-1:0]      cfg_high,
  input  logic [DIV_W-1:0]      cfg_phase,
  output logic [NUM_CLOCKS-1:0] outclk,
  output logic [NUM_CLOCKS-1:0] outclk_en,
  output logic                  locked
);

  localparam int SET_W = $clog2(LOCK_CYCLES + 1);

  logic [1:0]            state_q, state_d;
  logic [SET_W-1:0]      settle_q, settle_d;
  logic                  run_q;
  logic                  chan_ok, fire, in_update;
  logic [NUM_CLOCKS-1:0] wr_en;

  assign chan_ok   = {1'b0, cfg_chan} < (CHAN_W + 1)'(NUM_CLOCKS);
  assign in_update = (state_q == ST_UPDATE);
  assign cfg_ready = run_q && !in_update;
  assign fire      = cfg_valid && cfg_ready && chan_ok;
  assign locked    = (state_q == ST_LOCKED);

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    case (state_q)
      ST_SETTLE: begin
        if (settle_q == '0) state_d  = ST_LOCKED;
        else                settle_d = settle_q - SET_W'(1);
      end
      ST_LOCKED: state_d = ST_LOCKED;
      ST_UPDATE: begin
        state_d  = ST_SETTLE;
        settle_d = SET_W'(LOCK_CYCLES - 1);
      end
      default: state_d = ST_SETTLE;
    endcase
    if (fire) state_d = ST_UPDATE;
  end

  // Settle reloads one extra count out of reset so the first edge acts as the entry edge
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_SETTLE;
      settle_q <= SET_W'(LOCK_CYCLES);
      run_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      run_q    <= 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_CLOCKS; i++) begin : g_chan
    assign wr_en[i] = fire && (cfg_chan == CHAN_W'(i));

    clkgen_chan #(.DIV_W(DIV_W)) u_chan (
      .refclk    (refclk),
      .rst_n     (rst_n),
      .wr_en     (wr_en[i]),
      .wr_div    (cfg_div),
      .wr_high   (cfg_high),
      .wr_phase  (cfg_phase),
      .resync    (in_update),
      .force_low (fire || in_update),
      .outclk    (outclk[i]),
      .outclk_en (outclk_en[i])
    );
  end

endmodule

// File: tb/tb_clkgen_div_n.sv
// Self-checking bench for clkgen_div_n: table-driven config writes plus
// hand-written back-to-back and reset sequences, checked by a scoreboard.
module tb_clkgen_div_n;

  localparam int NCH = 3;
  localparam int DW  = 16;
  localparam int LC  = 16;

  logic           refclk = 1'b0;
  logic           rst_n = 1'b0;
  logic           cfg_valid = 1'b0;
  logic           cfg_ready;
  logic [1:0]     cfg_chan = '0;
  logic [DW-1:0]  cfg_div = '0, cfg_high = '0, cfg_phase = '0;
  logic [NCH-1:0] outclk, outclk_en;
  logic           locked;

  clkgen_div_n #(.NUM_CLOCKS(NCH), .DIV_W(DW), .LOCK_CYCLES(LC)) dut (
    .refclk    (refclk),
    .rst_n     (rst_n),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_chan  (cfg_chan),
    .cfg_div   (cfg_div),
    .cfg_high  (cfg_high),
    .cfg_phase (cfg_phase),
    .outclk    (outclk),
    .outclk_en (outclk_en),
    .locked    (locked)
  );

  always #5 refclk = ~refclk;

  typedef struct {
    int chan; int div; int high; int phase;
    int e_div; int e_high; int e_phase;
  } vec_t;

  typedef logic [2*NCH:0] obs_t;

  vec_t vecs[7];
  obs_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Model: n counts edges since reset release; channel c shows period position
  // (ld + m - t0) mod div from edge t0 on, and is held low before t0.
  int n, lock_ref, upd_edge;
  int t0[NCH], ld[NCH], dv[NCH], hi[NCH], ph[NCH];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, n);
    end
  endtask

  task automatic model_reset();
    n = 0;
    lock_ref = 0;
    upd_edge = -100;
    for (int c = 0; c < NCH; c++) begin
      t0[c] = 1; ld[c] = 0; dv[c] = 2; hi[c] = 1; ph[c] = 0;
    end
  endtask

  function automatic obs_t model_out(input int m);
    obs_t o;
    o = '0;
    for (int c = 0; c < NCH; c++) begin
      if (m >= t0[c]) begin
        int p;
        p = (ld[c] + m - t0[c]) % dv[c];
        o[c]       = (p < hi[c]);
        o[NCH + c] = (p == 0);
      end
    end
    o[2*NCH] = ((m - lock_ref) >= LC + 1);
    return o;
  endfunction

  task automatic step(input logic v, input int ch, input int d, input int h, input int p,
                      input int ed, input int eh, input int ep);
    logic rdy_exp;
    obs_t got, e;
    cfg_valid = v;
    cfg_chan  = 2'(ch);
    cfg_div   = DW'(d);
    cfg_high  = DW'(h);
    cfg_phase = DW'(p);
    #1;
    rdy_exp = (n >= 1) && (upd_edge != n);
    if (v) check("cfg_ready", 32'(cfg_ready), 32'(rdy_exp));
    if (v && rdy_exp && ch < NCH) begin
      dv[ch] = ed; hi[ch] = eh; ph[ch] = ep;
      lock_ref = n + 1;
      upd_edge = n + 1;
      for (int c = 0; c < NCH; c++) begin
        t0[c] = n + 3;
        ld[c] = (ph[c] == 0) ? 0 : dv[c] - ph[c];
      end
    end
    exp_q.push_back(model_out(n + 1));
    @(posedge refclk);
    #1;
    n++;
    cfg_valid = 1'b0;
    got = {locked, outclk_en, outclk};
    e = exp_q.pop_front();
    check("outputs{locked,en,clk}", 32'(got), 32'(e));
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) step(1'b0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic check_reset_outputs();
    check("rst_outclk", 32'(outclk), 32'd0);
    check("rst_outclk_en", 32'(outclk_en), 32'd0);
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_cfg_ready", 32'(cfg_ready), 32'd0);
  endtask

  initial begin
    //           chan div high phase  e_div e_high e_phase
    vecs[0] = '{1, 5, 2, 0, 5, 2, 0};
    vecs[1] = '{2, 8, 4, 3, 8, 4, 3};
    vecs[2] = '{0, 1, 0, 0, 2, 1, 0};
    vecs[3] = '{1, 4, 9, 7, 4, 3, 3};
    vecs[4] = '{3, 6, 2, 1, 0, 0, 0};
    vecs[5] = '{0, 3, 3, 5, 3, 2, 2};
    vecs[6] = '{2, 0, 5, 0, 2, 1, 0};

    model_reset();
    repeat (2) @(posedge refclk);
    #1;
    check_reset_outputs();
    rst_n = 1'b1;

    idle(25);

    for (int v = 0; v < 7; v++) begin
      step(1'b1, vecs[v].chan, vecs[v].div, vecs[v].high, vecs[v].phase,
           vecs[v].e_div, vecs[v].e_high, vecs[v].e_phase);
      idle(30);
    end

    for (int k = 0; k < 8; k++) begin
      step(1'b1, k % 3, k + 2, 1, 0, k + 2, 1, 0);
      idle(4);
    end
    idle(25);

    step(1'b1, 0, 6, 3, 0, 6, 3, 0);
    idle(2);
    check("pre_rst_outclk0", 32'(outclk[0]), 32'd1);
    rst_n = 1'b0;
    #2;
    check_reset_outputs();
    model_reset();
    @(posedge refclk);
    #1;
    rst_n = 1'b1;
    idle(25);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
